// File: rtl/hashtable_pkg.sv
// hashtable_pkg: shared FSM states, word width and bit-modify helper for the bitmap hashtable
package hashtable_pkg;
  localparam int BM_WORD_W = 8;
  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, CLR} bm_ctrl_state_t;
  function automatic logic [BM_WORD_W-1:0] bm_rmw(input logic [BM_WORD_W-1:0] q, input logic [2:0] bit_idx, input logic set);
    logic [BM_WORD_W-1:0] m;
    m = BM_WORD_W'(1) << bit_idx;
    return set ? (q | m) : (q & ~m);
  endfunction
endpackage

// File: rtl/hashtable_bm_ctrl.sv
// hashtable_bm_ctrl: read-modify-write bit updates and optional full clear (HT_CLR_ALL_EN) on bitmap RAM port A
module hashtable_bm_ctrl
  import hashtable_pkg::*;
#(
  parameter int NBITS = 15,
  parameter int BM_AWIDTH = NBITS-3,
  parameter int RAM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 upd_valid,
  output logic                 upd_ready,
  input  logic [NBITS-1:0]     upd_addr,
  input  logic                 upd_set,
  input  logic                 clr_valid,
  output logic                 clr_ready,
  output logic                 clr_done,
  output logic                 busy,
  output logic [15:0]          upd_cnt,
  input  logic [BM_AWIDTH-1:0] lkp_addr,
  input  logic                 lkp_valid,
  output logic                 lkp_ready,
  output logic [BM_AWIDTH-1:0] ram_addr_a,
  output logic                 ram_rden_a,
  output logic                 ram_wren_a,
  output logic [7:0]           ram_wdata_a,
  input  logic [7:0]           ram_q_a
);
  bm_ctrl_state_t state_q, state_d;
  logic [BM_AWIDTH-1:0] waddr_q, waddr_d;
  logic [2:0] bidx_q, bidx_d;
  logic set_q, set_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic idle, own, clr_go;
  logic [BM_AWIDTH-1:0] fsm_addr;
  logic fsm_rden, fsm_wren;
  logic [BM_WORD_W-1:0] fsm_wdata;
  assign idle = state_q == IDLE;
  assign own = (state_q == RD) | (state_q == WR) | (state_q == CLR);
`ifdef HT_CLR_ALL_EN
  logic [BM_AWIDTH-1:0] ptr_q, ptr_d;
  logic clr_done_q, clr_done_d;
  assign clr_go = idle & clr_valid;
  assign clr_ready = idle;
  assign clr_done = clr_done_q;
`else
  logic unused_clr_valid;
  assign unused_clr_valid = clr_valid;
  assign clr_go = 1'b0;
  assign clr_ready = 1'b0;
  assign clr_done = 1'b0;
`endif
  assign upd_ready = idle & ~clr_go;
  assign busy = ~idle;
  assign upd_cnt = cnt_q;
  assign lkp_ready = ~own;
  assign ram_addr_a = own ? fsm_addr : lkp_addr;
  assign ram_rden_a = own ? fsm_rden : lkp_valid;
  assign ram_wren_a = own & fsm_wren;
  assign ram_wdata_a = fsm_wdata;
  // next state, latched update fields and FSM-side port A drive
  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    bidx_d = bidx_q;
    set_d = set_q;
    cnt_d = cnt_q;
    wcnt_d = wcnt_q;
    fsm_addr = waddr_q;
    fsm_rden = 1'b0;
    fsm_wren = 1'b0;
    fsm_wdata = bm_rmw(ram_q_a, bidx_q, set_q);
`ifdef HT_CLR_ALL_EN
    ptr_d = ptr_q;
    clr_done_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (clr_go) state_d = CLR;
        else if (upd_valid) begin
          waddr_d = upd_addr[NBITS-1:3];
          bidx_d = upd_addr[2:0];
          set_d = upd_set;
          state_d = RD;
        end
      end
      RD: begin
        fsm_rden = 1'b1;
        wcnt_d = '0;
        state_d = (RAM_LATENCY > 1) ? WAIT : WR;
      end
      WAIT: begin
        wcnt_d = wcnt_q + 8'd1;
        state_d = (wcnt_q == 8'(RAM_LATENCY-2)) ? WR : WAIT;
      end
      WR: begin
        fsm_wren = 1'b1;
        cnt_d = cnt_q + 16'd1;
        state_d = IDLE;
      end
`ifdef HT_CLR_ALL_EN
      CLR: begin
        fsm_addr = ptr_q;
        fsm_wren = 1'b1;
        fsm_wdata = '0;
        ptr_d = (ptr_q == '1) ? '0 : ptr_q + BM_AWIDTH'(1);
        clr_done_d = ptr_q == '1;
        state_d = (ptr_q == '1) ? IDLE : CLR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset abandons any update or sweep in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      waddr_q <= '0;
      bidx_q <= '0;
      set_q <= 1'b0;
      cnt_q <= '0;
      wcnt_q <= '0;
`ifdef HT_CLR_ALL_EN
      ptr_q <= '0;
      clr_done_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      bidx_q <= bidx_d;
      set_q <= set_d;
      cnt_q <= cnt_d;
      wcnt_q <= wcnt_d;
`ifdef HT_CLR_ALL_EN
      ptr_q <= ptr_d;
      clr_done_q <= clr_done_d;
`endif
    end
  end
endmodule
